// File: rtl/issue_scoreboard.sv
// issue_scoreboard: per-register pending-write tracking, hazard stalls and serializing-instruction issue control
module issue_scoreboard #(
  parameter int CNT_W = 2,
  parameter int MAX_OUTSTANDING = 8,
  parameter int OUT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_valid,
  input  logic             dec_rs1_read,
  input  logic             dec_rs2_read,
  input  logic [4:0]       dec_rs1_regid,
  input  logic [4:0]       dec_rs2_regid,
  input  logic             dec_reg_write,
  input  logic [4:0]       dec_reg_regid,
  input  logic             dec_serialize,
  output logic             dec_ready,
  output logic             issue_fire,
  input  logic             wb_valid,
  input  logic [4:0]       wb_regid,
  input  logic             kill_valid,
  input  logic [4:0]       kill_regid,
  input  logic             serialize_done,
  output logic [OUT_W-1:0] pending_count,
  output logic             busy,
  output logic             err_underflow
);
  typedef enum logic [1:0] {RUN, DRAIN, WAIT} state_t;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  state_t           state;
  logic [CNT_W-1:0] cnt [32];
  logic [CNT_W-1:0] cnt_nx [32];
  logic [CNT_W:0]   sum [32];
  logic [1:0]       dcr [32];
  logic             ovf [32];
  logic [OUT_W-1:0] pend_nx;
  logic             stall, uf, wr_ok;
  assign wr_ok = dec_reg_write && dec_reg_regid != 5'd0;
  always_comb begin
    stall = (dec_rs1_read && dec_rs1_regid != 5'd0 && cnt[dec_rs1_regid] != '0) ||
            (dec_rs2_read && dec_rs2_regid != 5'd0 && cnt[dec_rs2_regid] != '0) ||
            (wr_ok && (cnt[dec_reg_regid] == CNT_MAX || pending_count == OUT_W'(MAX_OUTSTANDING)));
    dec_ready = !rst && !stall && (state == RUN ? (!dec_serialize || pending_count == '0) :
                state == DRAIN && dec_serialize && pending_count == '0);
  end
  assign issue_fire = dec_valid && dec_ready;
  assign busy = state != RUN || pending_count != '0;
  // Decrements beyond what a register actually owes clamp to zero and only the real amount leaves the total
  always_comb begin
    sum = '{default: '0};
    dcr = '{default: '0};
    ovf = '{default: 1'b0};
    cnt_nx = cnt;
    uf = 1'b0;
    pend_nx = pending_count + OUT_W'(issue_fire && wr_ok);
    for (int r = 1; r < 32; r++) begin
      sum[r] = {1'b0, cnt[r]} + (CNT_W+1)'(issue_fire && wr_ok && dec_reg_regid == 5'(r));
      dcr[r] = 2'(wb_valid && wb_regid == 5'(r)) + 2'(kill_valid && kill_regid == 5'(r));
      ovf[r] = (CNT_W+1)'(dcr[r]) > sum[r];
      uf = uf || ovf[r];
      cnt_nx[r] = ovf[r] ? '0 : CNT_W'(sum[r] - (CNT_W+1)'(dcr[r]));
      pend_nx = pend_nx - (ovf[r] ? OUT_W'(sum[r]) : OUT_W'(dcr[r]));
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt <= '{default: '0};
      pending_count <= '0;
      err_underflow <= 1'b0;
    end else begin
      cnt <= cnt_nx;
      pending_count <= pend_nx;
      err_underflow <= err_underflow || uf;
      state <= state == WAIT ? (serialize_done ? RUN : WAIT) :
               issue_fire && dec_serialize ? WAIT :
               state == DRAIN ? (dec_valid ? DRAIN : RUN) :
               (dec_valid && dec_serialize && pending_count != '0 ? DRAIN : RUN);
    end
  end
endmodule

// File: tb/tb_issue_scoreboard.sv
// tb_issue_scoreboard: directed scoreboard bench for issue_scoreboard
module tb_issue_scoreboard;
  logic clk = 1'b0, rst = 1'b1;
  logic dec_valid, dec_rs1_read, dec_rs2_read, dec_reg_write, dec_serialize;
  logic [4:0] dec_rs1_regid, dec_rs2_regid, dec_reg_regid, wb_regid, kill_regid;
  logic wb_valid, kill_valid, serialize_done;
  logic dec_ready, issue_fire, busy, err_underflow;
  logic [3:0] pending_count;
  typedef struct {string tag; logic [7:0] v;} exp_t;
  exp_t q[$];
  int vectors = 0, fails = 0;

  issue_scoreboard dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rs1_read(dec_rs1_read),
    .dec_rs2_read(dec_rs2_read), .dec_rs1_regid(dec_rs1_regid), .dec_rs2_regid(dec_rs2_regid),
    .dec_reg_write(dec_reg_write), .dec_reg_regid(dec_reg_regid), .dec_serialize(dec_serialize),
    .dec_ready(dec_ready), .issue_fire(issue_fire), .wb_valid(wb_valid), .wb_regid(wb_regid),
    .kill_valid(kill_valid), .kill_regid(kill_regid), .serialize_done(serialize_done),
    .pending_count(pending_count), .busy(busy), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  task automatic drv(input logic v, input logic r1r, input logic [4:0] r1, input logic r2r,
                     input logic [4:0] r2, input logic w, input logic [4:0] rd, input logic s);
    dec_valid = v; dec_rs1_read = r1r; dec_rs1_regid = r1; dec_rs2_read = r2r;
    dec_rs2_regid = r2; dec_reg_write = w; dec_reg_regid = rd; dec_serialize = s;
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic exp_push(input string tag, input logic r, input logic f, input int p,
                          input logic b, input logic e);
    exp_t x;
    x.tag = tag;
    x.v = {r, f, 4'(p), b, e};
    q.push_back(x);
  endtask

  task automatic sample();
    exp_t x;
    logic [7:0] obs;
    #1;
    x = q.pop_front();
    obs = {dec_ready, issue_fire, pending_count, busy, err_underflow};
    vectors++;
    assert (obs === x.v) else begin
      fails++;
      $error("FAIL %s observed rdy,fire,pend,busy,err=%b expected=%b", x.tag, obs, x.v);
    end
  endtask

  task automatic chk(input string tag, input logic r, input logic f, input int p,
                     input logic b, input logic e);
    exp_push(tag, r, f, p, b, e);
    sample();
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    idle();
    wb_valid = 0; wb_regid = 0; kill_valid = 0; kill_regid = 0; serialize_done = 0;
    cyc(); cyc();
    drv(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0);
    chk("rst_hold", 0, 0, 0, 0, 0);
    cyc(); rst = 1'b0;
    // RAW on x5
    drv(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0);
    chk("issue_x5", 1, 1, 0, 0, 0);
    cyc(); drv(1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    chk("raw_stall", 0, 0, 1, 1, 0);
    wb_valid = 1; wb_regid = 5;
    chk("raw_nobypass", 0, 0, 1, 1, 0);
    cyc(); wb_valid = 0;
    chk("raw_release", 1, 1, 0, 0, 0);
    // counter saturation on x7
    for (int i = 0; i < 3; i++) begin
      cyc(); drv(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0);
      chk("sat_issue", 1, 1, i, i != 0, 0);
    end
    cyc(); chk("sat_stall", 0, 0, 3, 1, 0);
    wb_valid = 1; wb_regid = 7;
    chk("sat_wb_cycle", 0, 0, 3, 1, 0);
    cyc(); wb_valid = 0;
    chk("sat_release", 1, 1, 2, 1, 0);
    cyc(); idle();
    chk("idle_ready", 1, 0, 3, 1, 0);
    wb_valid = 1; wb_regid = 7;
    cyc(); cyc(); cyc(); wb_valid = 0;
    chk("sat_drained", 1, 0, 0, 0, 0);
    // capacity
    for (int i = 1; i <= 8; i++) begin
      drv(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'(i), 1'b0);
      chk("cap_fill", 1, 1, i - 1, i > 1, 0);
      cyc();
    end
    drv(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9, 1'b0);
    chk("cap_stall", 0, 0, 8, 1, 0);
    drv(1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0);
    chk("cap_x0", 1, 1, 8, 1, 0);
    cyc(); idle();
    for (int i = 3; i <= 8; i++) begin
      wb_valid = 1; wb_regid = 5'(i);
      cyc();
    end
    wb_valid = 0;
    chk("cap_drain", 1, 0, 2, 1, 0);
    // serialize: DRAIN then WAIT
    drv(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
    chk("ser_hold", 0, 0, 2, 1, 0);
    cyc(); wb_valid = 1; wb_regid = 1;
    chk("drain_a", 0, 0, 2, 1, 0);
    cyc(); wb_regid = 2;
    chk("drain_b", 0, 0, 1, 1, 0);
    cyc(); wb_valid = 0;
    chk("ser_fire", 1, 1, 0, 1, 0);
    cyc(); drv(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd10, 1'b0);
    chk("wait_stall", 0, 0, 0, 1, 0);
    serialize_done = 1;
    chk("wait_done_cycle", 0, 0, 0, 1, 0);
    cyc(); serialize_done = 0;
    chk("wait_release", 1, 1, 0, 0, 0);
    cyc(); idle();
    chk("post_wait", 1, 0, 1, 1, 0);
    wb_valid = 1; wb_regid = 10;
    cyc(); wb_valid = 0;
    // issue + wb + kill in one cycle
    drv(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 1'b0);
    chk("issue_x3", 1, 1, 0, 0, 0);
    cyc(); drv(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd4, 1'b0);
    chk("issue_x4", 1, 1, 1, 1, 0);
    cyc(); drv(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 1'b0);
    wb_valid = 1; wb_regid = 3; kill_valid = 1; kill_regid = 4;
    chk("same_cycle", 1, 1, 2, 1, 0);
    cyc(); wb_valid = 0; kill_valid = 0;
    drv(1'b1, 1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    chk("kill_cleared", 1, 1, 1, 1, 0);
    drv(1'b1, 1'b0, 5'd0, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0);
    chk("cnt3_kept", 0, 0, 1, 1, 0);
    idle(); wb_valid = 1; wb_regid = 3;
    cyc(); wb_valid = 0;
    // underflow
    drv(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd11, 1'b0);
    chk("issue_x11", 1, 1, 0, 0, 0);
    cyc(); idle(); wb_valid = 1; wb_regid = 9;
    chk("pre_underflow", 1, 0, 1, 1, 0);
    cyc(); wb_valid = 0;
    chk("underflow", 1, 0, 1, 1, 1);
    cyc(); chk("sticky", 1, 0, 1, 1, 1);
    // async reset in DRAIN
    drv(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
    chk("ser_hold2", 0, 0, 1, 1, 1);
    cyc();
    exp_push("async_rst", 0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    sample();
    cyc(); rst = 1'b0;
    drv(1'b1, 1'b1, 5'd11, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    chk("post_rst", 1, 1, 0, 0, 0);
    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule

// File: doc/issue_scoreboard.md
# issue_scoreboard

Register-hazard scoreboard and issue controller between the decoder and the execute stage of the veriRISCV core. It tracks, per architectural register, how many issued instructions still owe a write. It stalls decoded instructions whose sources or destination conflict with in-flight writes. It also serializes CSR/MRET/trap-class instructions by draining all outstanding writes before issuing them and holding issue until they complete.

## Interface
Parameters:
- CNT_W, 2, width of each per-register pending-write counter (saturates at 2^CNT_W-1)
- MAX_OUTSTANDING, 8, maximum total in-flight register writes
- OUT_W, $clog2(MAX_OUTSTANDING+1), width of pending_count

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous, active-high reset
- dec_valid  input  1  decoded instruction present
- dec_rs1_read / dec_rs2_read  input  1  source read flags from decoder
- dec_rs1_regid / dec_rs2_regid  input  5  source register ids
- dec_reg_write  input  1  instruction writes rd
- dec_reg_regid  input  5  rd id
- dec_serialize  input  1  CSR access, MRET or illegal instruction; must issue alone
- dec_ready  output  1  issue permitted this cycle
- issue_fire  output  1  dec_valid & dec_ready
- wb_valid / wb_regid  input  1 / 5  a tracked write retires to the register file
- kill_valid / kill_regid  input  1 / 5  a tracked in-flight write is squashed by a flush
- serialize_done  input  1  the issued serializing instruction has completed
- pending_count  output  OUT_W  total in-flight tracked writes
- busy  output  1  state != RUN or pending_count != 0
- err_underflow  output  1  sticky; a decrement hit a zero counter

## Operation
- Register x0 is never tracked. Writes to x0 and reads of x0 never stall, and wb/kill with regid 0 is ignored.
- cnt[r] (r=1..31) holds the in-flight write count for register r.
- Next value of cnt[r]: cnt[r] + inc - dwb - dkill.
  - inc = issue_fire & dec_reg_write & rd==r.
  - dwb = wb_valid & wb_regid==r.
  - dkill = kill_valid & kill_regid==r.
  - All three can occur in the same cycle, on the same or different registers.
- pending_count tracks the sum of all cnt[r], applying the same net arithmetic.
- Underflow: if the decrements on a register exceed cnt+inc, cnt clamps to 0, pending_count is reduced only by the valid amount, and err_underflow is set. err_underflow clears only on rst.
- Stall conditions, evaluated on registered counters only with no same-cycle wb bypass. dec_ready=0 if any of:
  - rs1 RAW: dec_rs1_read & rs1!=0 & cnt[rs1]!=0
  - rs2 RAW: the same test for rs2
  - rd saturation: dec_reg_write & rd!=0 & cnt[rd]==2^CNT_W-1
  - capacity: dec_reg_write & rd!=0 & pending_count==MAX_OUTSTANDING
  - FSM blocks issue (see below)
- dec_ready is computed regardless of dec_valid. Only issue_fire changes state.
- FSM states:
  - RUN: a non-serializing instruction follows the stall rules. A serializing instruction is ready only if pending_count==0. If dec_valid & dec_serialize & pending_count!=0, go to DRAIN (dec_ready=0). If a serializing instruction fires, go to WAIT.
  - DRAIN: dec_ready = dec_serialize & pending_count==0 & no stall. On fire, go to WAIT. If dec_valid falls (front-end flush), go to RUN.
  - WAIT: dec_ready=0. On serialize_done, go to RUN; issue resumes the next cycle. A serializing instruction's own rd write is tracked like any other.
- Reset state:
  - all cnt 0, state RUN, pending_count 0, err_underflow 0, busy 0.
  - While rst is asserted, dec_ready=0 and issue_fire=0.
  - Asserting rst mid-operation discards all tracking immediately.

## Timing
- dec_ready and issue_fire are combinational from registered state and the current dec_* inputs. There is no register in the issue path.
- Counters, pending_count and state update at the rising clk edge following the event.
- RAW release: a wb in cycle N clears the hazard, and the dependent instruction fires in N+1 at the earliest. The minimum bubble is one cycle.
- Issue and writeback of the same rd in one cycle: the count is unchanged (+1-1).
- Serialize latency: fire occurs no earlier than the cycle after pending_count reaches 0. Issue resumes the cycle after serialize_done is sampled in WAIT.
- serialize_done outside WAIT is ignored.

## Test plan
- Reset, then issue add x5 with dec_valid=1 -> issue_fire=1 that cycle. Next cycle cnt[5]=1 and pending_count=1. Next instruction reads x5 -> dec_ready=0 until the cycle after wb_valid/wb_regid=5.
- Issue three writes to x7 with CNT_W=2 -> the third fires and cnt=3. A fourth write to x7 stalls. A wb to x7 in cycle N lets the fourth fire in N+1.
- Issue eight writes to x1..x8 -> pending_count=8. A ninth write stalls. A ninth instruction with only rs reads of x0 fires.
- With pending_count=2, present a serializing instruction -> state DRAIN, dec_ready=0. Two wb retire. It fires one cycle after the count reaches 0 and the state goes to WAIT. Non-serializing instructions stall until serialize_done, then fire the next cycle.
- Same cycle: issue rd=3, wb 3, kill 4, with cnt[3]=1 and cnt[4]=1 -> cnt[3]=1, cnt[4]=0, pending_count 2->1.
- wb_regid=9 with cnt[9]=0 -> err_underflow=1 (sticky) and pending_count unchanged. Async rst mid-DRAIN -> all outputs return to their reset values immediately.
